// File: rtl/jtframe_neptuno_joyser.sv
// rtl/jtframe_neptuno_joyser.sv - serial reader for two joysticks on a 74HC165 chain
//
// Scans a 16-bit 74HC165 chain once per frame: one parallel-load period,
// then 16 shift-clock pulses, then a single DONE clock. The DONE clock
// publishes both players through a two-frame agreement filter.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   joy_data   : serial data from the chain (asynchronous to clk)
//   joy_clk    : shift clock to the chain, chain shifts on its rising edge
//   joy_load   : parallel-load strobe to the chain, active-low
//   joy1, joy2 : {fire2, fire1, up, down, left, right}, active-low
//   frame_done : one-clk pulse when a frame has been scanned
module jtframe_neptuno_joyser #(
    parameter int unsigned DIV = 24     // clk cycles per joy_clk half-period, 4..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load,
    output logic [5:0] joy1,
    output logic [5:0] joy2,
    output logic       frame_done
);

    typedef enum logic [1:0] {LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  presc_q, presc_d;
    logic [3:0]  idx_q, idx_d;
    logic [11:0] sr_q, sr_d;          // only the 12 used chain bits are kept
    logic [5:0]  prev1_q, prev1_d;
    logic [5:0]  prev2_q, prev2_d;
    logic [5:0]  joy1_q, joy1_d;
    logic [5:0]  joy2_q, joy2_d;
    logic [1:0]  sync_q;
    logic        joy_clk_q, joy_clk_d;
    logic        joy_load_q, joy_load_d;
    logic        frame_done_q, frame_done_d;

    logic        tick;
    logic        sr_used;
    logic [3:0]  sr_pos;

    // Chain order is up, down, left, right, fire1, fire2 per player.
    function automatic logic [5:0] to_joy(input logic [5:0] raw);
        return {raw[5], raw[4], raw[0], raw[1], raw[2], raw[3]};
    endfunction

    assign tick = (presc_q == DIV_M1);

    // Chain bits 6,7,14,15 are unused; bits 8..13 pack into positions 6..11.
    assign sr_used = (idx_q[2:0] < 3'd6);
    assign sr_pos  = idx_q[3] ? (4'd6 + {1'b0, idx_q[2:0]}) : {1'b0, idx_q[2:0]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        prev1_d = prev1_q;
        prev2_d = prev2_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        // The prescaler is cleared in DONE so the LOAD period after it is a
        // full DIV clocks and every frame is 33*DIV+1 clocks long.
        presc_d = (state_q == DONE || tick) ? 8'd0 : presc_q + 8'd1;

        case (state_q)
            LOAD: begin
                if (tick) begin
                    idx_d   = 4'd0;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                // Sampled at the end of the low half, well after the
                // previous rising edge has settled the chain output.
                if (tick) begin
                    if (sr_used) begin
                        sr_d[sr_pos] = sync_q[1];
                    end
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SHIFT_LO;
                    end
                end
            end
            DONE: begin
                // A player only updates when two consecutive frames agree.
                prev1_d = sr_q[5:0];
                prev2_d = sr_q[11:6];
                if (sr_q[5:0] == prev1_q) begin
                    joy1_d = to_joy(sr_q[5:0]);
                end
                if (sr_q[11:6] == prev2_q) begin
                    joy2_d = to_joy(sr_q[11:6]);
                end
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // Chain strobes are registered decodes of the current state, so each
    // level lasts exactly as long as its state and is glitch-free.
    always_comb begin
        joy_clk_d    = (state_q == SHIFT_HI);
        joy_load_d   = (state_q != LOAD);
        frame_done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            presc_q      <= 8'd0;
            idx_q        <= 4'd0;
            sr_q         <= 12'hFFF;
            prev1_q      <= 6'h3F;
            prev2_q      <= 6'h3F;
            joy1_q       <= 6'h3F;
            joy2_q       <= 6'h3F;
            sync_q       <= 2'b11;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            sr_q         <= sr_d;
            prev1_q      <= prev1_d;
            prev2_q      <= prev2_d;
            joy1_q       <= joy1_d;
            joy2_q       <= joy2_d;
            sync_q       <= {sync_q[0], joy_data};
            joy_clk_q    <= joy_clk_d;
            joy_load_q   <= joy_load_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign joy_clk    = joy_clk_q;
    assign joy_load   = joy_load_q;
    assign joy1       = joy1_q;
    assign joy2       = joy2_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_jtframe_neptuno_joyser.sv
// tb/tb_jtframe_neptuno_joyser.sv - self-checking bench for jtframe_neptuno_joyser
module tb_jtframe_neptuno_joyser;

    localparam int DIV   = 4;
    localparam int FRAME = 33 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       joy_data = 1'b1;
    logic       joy_clk;
    logic       joy_load;
    logic [5:0] joy1;
    logic [5:0] joy2;
    logic       frame_done;

    int n_checks = 0;
    int n_bad    = 0;

    // 74HC165 chain model and reference state
    logic [15:0] next_word  = 16'hFFFF;
    logic [15:0] frame_word = 16'hFFFF;
    int          k          = 0;
    logic        clk_prev   = 1'b0;
    logic [5:0]  prev1      = 6'h3F;
    logic [5:0]  prev2      = 6'h3F;
    logic [5:0]  exp1       = 6'h3F;
    logic [5:0]  exp2       = 6'h3F;
    int          cyc        = 0;
    int          load_low   = 0;
    int          high_cnt   = 0;
    int          rises      = 0;

    logic [15:0] words[$];

    always #5 clk = ~clk;

    jtframe_neptuno_joyser #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .joy_data   (joy_data),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy1       (joy1),
        .joy2       (joy2),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // raw is the chain slice for one player: up, down, left, right, fire1, fire2
    function automatic logic [5:0] buttons(input logic [5:0] raw);
        logic up, down, left, right, fire1, fire2;
        up    = raw[0];
        down  = raw[1];
        left  = raw[2];
        right = raw[3];
        fire1 = raw[4];
        fire2 = raw[5];
        return {fire2, fire1, up, down, left, right};
    endfunction

    // Chain model, reference model and per-cycle checks, all at negedge.
    // Data is only valid while joy_clk is low; during the high half the
    // model drives the inverted bit so a sample taken then is caught.
    initial begin
        logic bitv;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_joy1", joy1, 6'h3F);
                check("rst_joy2", joy2, 6'h3F);
                check("rst_load", joy_load, 1'b1);
                check("rst_clk", joy_clk, 1'b0);
                check("rst_done", frame_done, 1'b0);
                prev1 = 6'h3F; prev2 = 6'h3F;
                exp1  = 6'h3F; exp2  = 6'h3F;
                cyc = 0; load_low = 0; high_cnt = 0; rises = 0;
                k = 0; clk_prev = 1'b0; joy_data = 1'b1;
            end else begin
                cyc++;
                if (!joy_load) load_low++;
                if (joy_clk) high_cnt++;
                if (!joy_load) begin
                    frame_word = next_word;
                    k = 0;
                end else if (joy_clk && !clk_prev) begin
                    k++;
                    rises++;
                end
                clk_prev = joy_clk;
                bitv     = (k < 16) ? frame_word[k] : 1'b1;
                joy_data = joy_clk ? ~bitv : bitv;

                check("load_vs_clk", {15'd0, (joy_load | ~joy_clk)}, 16'd1);

                if (frame_done) begin
                    check("frame_period", 16'(cyc), 16'(FRAME));
                    check("load_low_len", 16'(load_low), 16'(DIV));
                    check("clk_high_len", 16'(high_cnt), 16'(32 * DIV / 2));
                    check("clk_rises", 16'(rises), 16'd16);
                    if (frame_word[5:0] == prev1) exp1 = buttons(frame_word[5:0]);
                    if (frame_word[13:8] == prev2) exp2 = buttons(frame_word[13:8]);
                    prev1 = frame_word[5:0];
                    prev2 = frame_word[13:8];
                    cyc = 0; load_low = 0; high_cnt = 0; rises = 0;
                end
                check("joy1", joy1, exp1);
                check("joy2", joy2, exp2);
            end
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 2 * FRAME);
        check("frame_timeout", frame_done, 1'b1);
    endtask

    initial begin
        logic [15:0] w;
        rst_n = 1'b0;

        words = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF,
                  16'hDFFF, 16'hFFFF, 16'hFFFF, 16'hC0C0, 16'hC0C0, 16'h0000,
                  16'h3F3F, 16'h3F3F, 16'hFFFF};
        w = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       w = 16'($urandom);
                1:       w = {w[15:8], 8'($urandom)};
                default: ;
            endcase
            words.push_back(w);
        end

        next_word = words[0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < words.size(); i++) begin
            next_word = words[i];
            wait_frame();
        end

        // Abort a frame in the middle of the shift sequence.
        next_word = 16'h0000;
        begin
            int n = 0;
            while (rises < 8 && n < 2 * FRAME) begin
                @(negedge clk);
                n++;
            end
            check("reset_point", {15'd0, rises >= 8}, 16'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        next_word = 16'hFFFE;
        #1 rst_n = 1'b1;
        wait_frame();
        next_word = 16'hFFFE;
        wait_frame();
        check("after_reset_joy1", joy1, 6'h37);
        check("after_reset_joy2", joy2, 6'h3F);
        next_word = 16'hFFFF;
        wait_frame();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
